// File: rtl/riscv_pkg.sv
// Shared RV64I definitions: widths, opcodes, branch funct3 codes, ALU and decode encodings.
package riscv_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = 5;

  // Major opcodes
  localparam logic [6:0] OP_LOAD      = 7'h03;
  localparam logic [6:0] OP_OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC     = 7'h17;
  localparam logic [6:0] OP_OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OP_STORE     = 7'h23;
  localparam logic [6:0] OP_OP        = 7'h33;
  localparam logic [6:0] OP_LUI       = 7'h37;
  localparam logic [6:0] OP_OP_32     = 7'h3B;
  localparam logic [6:0] OP_BRANCH    = 7'h63;
  localparam logic [6:0] OP_JALR      = 7'h67;
  localparam logic [6:0] OP_JAL       = 7'h6F;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Writeback result select
  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9,
    AluAddW = 4'd10,
    AluSubW = 4'd11
  } aluControl_t;

  typedef enum logic [2:0] {
    ImmI = 3'd0,
    ImmS = 3'd1,
    ImmB = 3'd2,
    ImmU = 3'd3,
    ImmJ = 3'd4
  } immSrc_t;

endpackage

// File: rtl/reg_file.sv
// 32 x XLEN register file, x0 hardwired to zero, combinational reads with write-through bypass.
module reg_file
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] a1,
  input  logic [REG_AW-1:0] a2,
  input  logic [REG_AW-1:0] a3,
  input  logic              we3,
  input  logic [XLEN-1:0]   wd3,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  // x0 has no storage
  logic [XLEN-1:0] regs [1:NUM_REGS-1];

  // Reset clears every register; reset also beats a concurrent writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we3 && (a3 != '0)) begin
      regs[a3] <= wd3;
    end
  end

  // Read port 1: x0 reads zero, same-cycle writeback is forwarded
  always_comb begin
    rd1 = '0;
    if (a1 != '0) begin
      rd1 = (we3 && (a3 == a1)) ? wd3 : regs[a1];
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rd2 = '0;
    if (a2 != '0) begin
      rd2 = (we3 && (a3 == a2)) ? wd3 : regs[a2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV64I decode: register file, immediate generation, control decode, branch/jump resolution
// and the D/E pipeline register.
module decode_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  output logic              PCSrcD,
  output logic              JalD,
  output logic [XLEN-1:0]   PCTargetD,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              ALUSrcE,
  output logic [1:0]        ResultSrcE,
  output logic [3:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic [REG_AW-1:0] rs1, rs2, rd;

  assign opcode   = InstrD[6:0];
  assign rd       = InstrD[11:7];
  assign funct3   = InstrD[14:12];
  assign rs1      = InstrD[19:15];
  assign rs2      = InstrD[24:20];
  assign funct7b5 = InstrD[30];

  logic        regWrite, memWrite, aluSrc;
  logic [1:0]  resultSrc;
  aluControl_t aluCtrl;
  immSrc_t     immSrc;
  logic        isBranch, isJal, isJalr, isAuipc, useRs1;

  // Main and ALU control decode; anything unrecognised stays a NOP
  always_comb begin
    regWrite  = 1'b0;
    memWrite  = 1'b0;
    aluSrc    = 1'b0;
    resultSrc = RESULT_ALU;
    aluCtrl   = AluAdd;
    immSrc    = ImmI;
    isBranch  = 1'b0;
    isJal     = 1'b0;
    isJalr    = 1'b0;
    isAuipc   = 1'b0;
    useRs1    = 1'b1;
    case (opcode)
      OP_OP, OP_OP_IMM: begin
        regWrite = 1'b1;
        aluSrc   = (opcode == OP_OP_IMM);
        unique case (funct3)
          3'b000: aluCtrl = ((opcode == OP_OP) && funct7b5) ? AluSub : AluAdd;
          3'b001: aluCtrl = AluSll;
          3'b010: aluCtrl = AluSlt;
          3'b011: aluCtrl = AluSltu;
          3'b100: aluCtrl = AluXor;
          3'b101: aluCtrl = funct7b5 ? AluSra : AluSrl;
          3'b110: aluCtrl = AluOr;
          3'b111: aluCtrl = AluAnd;
        endcase
      end
      OP_OP_32, OP_OP_IMM_32: begin
        regWrite = 1'b1;
        aluSrc   = (opcode == OP_OP_IMM_32);
        // The ALU encoding has no word-sized shifts; those map onto the full-width codes
        case (funct3)
          3'b000:  aluCtrl = ((opcode == OP_OP_32) && funct7b5) ? AluSubW : AluAddW;
          3'b001:  aluCtrl = AluSll;
          3'b101:  aluCtrl = funct7b5 ? AluSra : AluSrl;
          default: aluCtrl = AluAddW;
        endcase
      end
      OP_LOAD: begin
        regWrite  = 1'b1;
        aluSrc    = 1'b1;
        resultSrc = RESULT_MEM;
      end
      OP_STORE: begin
        memWrite = 1'b1;
        aluSrc   = 1'b1;
        immSrc   = ImmS;
      end
      OP_BRANCH: begin
        isBranch = 1'b1;
        immSrc   = ImmB;
      end
      OP_JAL: begin
        regWrite  = 1'b1;
        resultSrc = RESULT_PC4;
        immSrc    = ImmJ;
        isJal     = 1'b1;
        useRs1    = 1'b0;
      end
      OP_JALR: begin
        regWrite  = 1'b1;
        resultSrc = RESULT_PC4;
        isJalr    = 1'b1;
      end
      // LUI/AUIPC read x0 so execute computes 0 + imm; AUIPC folds the PC into the immediate
      OP_LUI: begin
        regWrite = 1'b1;
        aluSrc   = 1'b1;
        immSrc   = ImmU;
        useRs1   = 1'b0;
      end
      OP_AUIPC: begin
        regWrite = 1'b1;
        aluSrc   = 1'b1;
        immSrc   = ImmU;
        useRs1   = 1'b0;
        isAuipc  = 1'b1;
      end
      default: ;
    endcase
  end

  logic [REG_AW-1:0] a1;
  logic [XLEN-1:0]   rd1, rd2;

  assign a1 = useRs1 ? rs1 : '0;

  reg_file u_reg_file (
    .clk (clk),
    .rst (rst),
    .a1  (a1),
    .a2  (rs2),
    .a3  (RdW),
    .we3 (RegWriteW),
    .wd3 (ResultW),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  logic [XLEN-1:0] immExt;

  // Immediate generator, sign-extended to XLEN
  always_comb begin
    immExt = '0;
    case (immSrc)
      ImmI: immExt = {{52{InstrD[31]}}, InstrD[31:20]};
      ImmS: immExt = {{52{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      ImmB: immExt = {{51{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      ImmU: immExt = {{32{InstrD[31]}}, InstrD[31:12], 12'b0};
      ImmJ: immExt = {{43{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21],
                      1'b0};
      default: immExt = '0;
    endcase
  end

  logic branchCond;

  // Branch comparison on the bypassed operands
  always_comb begin
    branchCond = 1'b0;
    case (funct3)
      F3_BEQ:  branchCond = (rd1 == rd2);
      F3_BNE:  branchCond = (rd1 != rd2);
      F3_BLT:  branchCond = ($signed(rd1) < $signed(rd2));
      F3_BGE:  branchCond = ($signed(rd1) >= $signed(rd2));
      F3_BLTU: branchCond = (rd1 < rd2);
      F3_BGEU: branchCond = (rd1 >= rd2);
      default: branchCond = 1'b0;
    endcase
  end

  logic [XLEN-1:0] immExtD;

  // Redirect outputs to fetch; PC arithmetic wraps silently
  always_comb begin
    PCSrcD    = isBranch & branchCond;
    JalD      = isJal | isJalr;
    PCTargetD = isJalr ? ((rd1 + immExt) & ~64'h1) : (PCD + immExt);
    immExtD   = isAuipc ? (PCD + immExt) : immExt;
  end

  // D/E pipeline register; reset or flush injects a bubble
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else begin
      RegWriteE   <= regWrite;
      MemWriteE   <= memWrite;
      ALUSrcE     <= aluSrc;
      ResultSrcE  <= resultSrc;
      ALUControlE <= aluCtrl;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= immExtD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= a1;
      Rs2E        <= rs2;
      RdE         <= rd;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD;
  logic [63:0] PCD, PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [63:0] ResultW;
  logic        FlushE;
  logic        PCSrcD, JalD;
  logic [63:0] PCTargetD;
  logic        RegWriteE, MemWriteE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [63:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  // {RegWrite, MemWrite, ALUSrc, ResultSrc[1:0], ALUControl[3:0]}
  logic [8:0]  ctrlE;
  assign ctrlE = {RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE};

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .RegWriteW   (RegWriteW),
    .RdW         (RdW),
    .ResultW     (ResultW),
    .FlushE      (FlushE),
    .PCSrcD      (PCSrcD),
    .JalD        (JalD),
    .PCTargetD   (PCTargetD),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .ALUSrcE     (ALUSrcE),
    .ResultSrcE  (ResultSrcE),
    .ALUControlE (ALUControlE),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .ImmExtE     (ImmExtE),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; InstrD = '0; PCD = '0; PCPlus4D = '0;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0; FlushE = 1'b0;
    step();
    step();
    nChecks++; if (ctrlE !== 9'b0) begin nFails++;
      $display("FAIL reset_ctrl: got %b want 0", ctrlE); end
    nChecks++; if ({RD1E, RD2E, ImmExtE, PCE, PCPlus4E} !== '0) begin nFails++;
      $display("FAIL reset_data: got %h %h %h %h %h want 0", RD1E, RD2E, ImmExtE, PCE, PCPlus4E); end
    nChecks++; if ({Rs1E, Rs2E, RdE} !== 15'b0) begin nFails++;
      $display("FAIL reset_idx: got %0d %0d %0d want 0", Rs1E, Rs2E, RdE); end
    nChecks++; if ({PCSrcD, JalD} !== 2'b00) begin nFails++;
      $display("FAIL reset_redirect: got %b want 00", {PCSrcD, JalD}); end
    rst = 1'b0;
    InstrD = 32'h007281B3;  // add x3,x5,x7
    step();
    nChecks++; if ({RD1E, RD2E} !== 128'b0) begin nFails++;
      $display("FAIL reset_regread: got %h %h want 0 0", RD1E, RD2E); end
    nChecks++; if (ctrlE !== 9'b1_0_0_00_0000) begin nFails++;
      $display("FAIL add_ctrl: got %b want 100000000", ctrlE); end
    nChecks++; if ({Rs1E, Rs2E, RdE} !== {5'd5, 5'd7, 5'd3}) begin nFails++;
      $display("FAIL add_idx: got %0d %0d %0d want 5 7 3", Rs1E, Rs2E, RdE); end
  endtask

  task automatic test_addi();
    InstrD = 32'h00500093;  // addi x1,x0,5
    step();
    nChecks++; if (ctrlE !== 9'b1_0_1_00_0000) begin nFails++;
      $display("FAIL addi_ctrl: got %b want 101000000", ctrlE); end
    nChecks++; if (ImmExtE !== 64'd5) begin nFails++;
      $display("FAIL addi_imm: got %h want 5", ImmExtE); end
    nChecks++; if ({Rs1E, RdE} !== {5'd0, 5'd1}) begin nFails++;
      $display("FAIL addi_idx: got rs1=%0d rd=%0d want 0 1", Rs1E, RdE); end
  endtask

  task automatic test_jalr_bypass();
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 64'h1001;
    InstrD = 32'h00008067;  // jalr x0,0(x1)
    #1;
    nChecks++; if ({JalD, PCSrcD} !== 2'b10) begin nFails++;
      $display("FAIL jalr_flags: got jal=%b src=%b want 1 0", JalD, PCSrcD); end
    nChecks++; if (PCTargetD !== 64'h1000) begin nFails++;
      $display("FAIL jalr_bypass_target: got %h want 1000", PCTargetD); end
    step();
    RegWriteW = 1'b0; ResultW = '0;
    #1;
    nChecks++; if (PCTargetD !== 64'h1000) begin nFails++;
      $display("FAIL jalr_stored_target: got %h want 1000", PCTargetD); end
    step();
    nChecks++; if (ctrlE !== 9'b1_0_0_10_0000) begin nFails++;
      $display("FAIL jalr_ctrl: got %b want 100100000", ctrlE); end
    nChecks++; if (RD1E !== 64'h1001) begin nFails++;
      $display("FAIL jalr_rd1: got %h want 1001", RD1E); end
  endtask

  task automatic test_alu_ops();
    logic [31:0] instr [8];
    logic [8:0]  expCtrl [8];
    logic [63:0] expImm [8];
    instr   = '{32'h402081B3, 32'h0020B423, 32'h800001B7, 32'h00001197,
                32'h4040D193, 32'h402081BB, 32'h0040A183, 32'hFFFFFFFF};
    expCtrl = '{9'b1_0_0_00_0001, 9'b0_1_1_00_0000, 9'b1_0_1_00_0000, 9'b1_0_1_00_0000,
                9'b1_0_1_00_0111, 9'b1_0_0_00_1011, 9'b1_0_1_01_0000, 9'b0_0_0_00_0000};
    // Only entries 1..6 carry a meaningful immediate check
    expImm  = '{64'h0, 64'h8, 64'hFFFFFFFF80000000, 64'h1400,
                64'h404, 64'h0, 64'h4, 64'h0};
    PCD = 64'h400; PCPlus4D = 64'h404;
    for (int i = 0; i < 8; i++) begin
      InstrD = instr[i];
      #1;
      if (i == 7) begin
        nChecks++; if ({PCSrcD, JalD} !== 2'b00) begin nFails++;
          $display("FAIL unknown_redirect: got %b want 00", {PCSrcD, JalD}); end
      end
      step();
      nChecks++; if (ctrlE !== expCtrl[i]) begin nFails++;
        $display("FAIL alu_ctrl[%0d]: instr %h got %b want %b", i, instr[i], ctrlE, expCtrl[i]); end
      if (i >= 1 && i <= 6 && i != 5) begin
        nChecks++; if (ImmExtE !== expImm[i]) begin nFails++;
          $display("FAIL alu_imm[%0d]: got %h want %h", i, ImmExtE, expImm[i]); end
      end
      if (i == 0) begin
        nChecks++; if ({RD1E, RD2E} !== {64'h1001, 64'h0}) begin nFails++;
          $display("FAIL sub_operands: got %h %h want 1001 0", RD1E, RD2E); end
      end
      if (i == 2 || i == 3) begin
        nChecks++; if (Rs1E !== 5'd0) begin nFails++;
          $display("FAIL upper_rs1[%0d]: got %0d want 0", i, Rs1E); end
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] instr [8];
    logic [63:0] pc [8];
    logic        expSrc [8];
    logic [63:0] expTgt [8];
    instr  = '{32'h00000463, 32'h00001463, 32'h00014463, 32'h00015463,
               32'h00016463, 32'h00017463, 32'hFE000EE3, 32'hFE000EE3};
    pc     = '{64'h100, 64'h100, 64'h100, 64'h100, 64'h100, 64'h100, 64'h100, 64'h0};
    expSrc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    expTgt = '{64'h108, 64'h108, 64'h108, 64'h108, 64'h108, 64'h108, 64'hFC,
               64'hFFFFFFFFFFFFFFFC};
    // x2 = -1 for signed/unsigned compares against x0
    RegWriteW = 1'b1; RdW = 5'd2; ResultW = '1; InstrD = '0;
    step();
    RegWriteW = 1'b0; ResultW = '0;
    for (int i = 0; i < 8; i++) begin
      PCD = pc[i];
      InstrD = instr[i];
      #1;
      nChecks++; if (PCSrcD !== expSrc[i]) begin nFails++;
        $display("FAIL br_taken[%0d]: instr %h got %b want %b", i, instr[i], PCSrcD, expSrc[i]); end
      nChecks++; if (PCTargetD !== expTgt[i]) begin nFails++;
        $display("FAIL br_target[%0d]: got %h want %h", i, PCTargetD, expTgt[i]); end
    end
    step();
    nChecks++; if (ctrlE !== 9'b0) begin nFails++;
      $display("FAIL br_ctrl: got %b want 0", ctrlE); end
  endtask

  task automatic test_jal();
    PCD = 64'h200; PCPlus4D = 64'h204;
    InstrD = 32'h010000EF;  // jal x1,+16
    #1;
    nChecks++; if ({JalD, PCSrcD} !== 2'b10) begin nFails++;
      $display("FAIL jal_flags: got jal=%b src=%b want 1 0", JalD, PCSrcD); end
    nChecks++; if (PCTargetD !== 64'h210) begin nFails++;
      $display("FAIL jal_target: got %h want 210", PCTargetD); end
    step();
    nChecks++; if (ctrlE !== 9'b1_0_0_10_0000) begin nFails++;
      $display("FAIL jal_ctrl: got %b want 100100000", ctrlE); end
    nChecks++; if ({PCE, PCPlus4E} !== {64'h200, 64'h204}) begin nFails++;
      $display("FAIL jal_pc: got %h %h want 200 204", PCE, PCPlus4E); end
    nChecks++; if ({Rs1E, RdE} !== {5'd0, 5'd1}) begin nFails++;
      $display("FAIL jal_idx: got rs1=%0d rd=%0d want 0 1", Rs1E, RdE); end
  endtask

  task automatic test_x0_flush();
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = '1;
    PCD = '0; InstrD = 32'h00000067;  // jalr x0,0(x0)
    #1;
    nChecks++; if (PCTargetD !== 64'h0) begin nFails++;
      $display("FAIL x0_bypass: got %h want 0", PCTargetD); end
    step();
    RegWriteW = 1'b0; ResultW = '0;
    InstrD = 32'h00000233;  // add x4,x0,x0
    step();
    nChecks++; if ({RD1E, RD2E} !== 128'b0) begin nFails++;
      $display("FAIL x0_read: got %h %h want 0 0", RD1E, RD2E); end
    FlushE = 1'b1; PCD = 64'h300; PCPlus4D = 64'h304;
    InstrD = 32'h00500093;
    step();
    nChecks++; if ({ctrlE, Rs1E, Rs2E, RdE} !== 24'b0) begin nFails++;
      $display("FAIL flush_ctrl: got %b %0d %0d %0d want 0", ctrlE, Rs1E, Rs2E, RdE); end
    nChecks++; if ({RD1E, RD2E, ImmExtE, PCE, PCPlus4E} !== '0) begin nFails++;
      $display("FAIL flush_data: got %h %h %h %h %h want 0", RD1E, RD2E, ImmExtE, PCE, PCPlus4E); end
    FlushE = 1'b0;
    step();
    nChecks++; if ({ctrlE, PCE} !== {9'b1_0_1_00_0000, 64'h300}) begin nFails++;
      $display("FAIL post_flush: got %b %h want 101000000 300", ctrlE, PCE); end
  endtask

  task automatic test_reset_writeback();
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 64'h55; InstrD = '0;
    step();
    RegWriteW = 1'b0; ResultW = '0;
    InstrD = 32'h007281B3;  // add x3,x5,x7
    step();
    nChecks++; if (RD1E !== 64'h55) begin nFails++;
      $display("FAIL wb_x5: got %h want 55", RD1E); end
    rst = 1'b1; RegWriteW = 1'b1; RdW = 5'd5; ResultW = 64'hABCD;
    step();
    nChecks++; if (ctrlE !== 9'b0) begin nFails++;
      $display("FAIL rst_wb_bubble: got %b want 0", ctrlE); end
    rst = 1'b0; RegWriteW = 1'b0; ResultW = '0;
    step();
    nChecks++; if (RD1E !== 64'h0) begin nFails++;
      $display("FAIL rst_wins: got %h want 0", RD1E); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_jalr_bypass();
    test_alu_ops();
    test_branch();
    test_jal();
    test_x0_flush();
    test_reset_writeback();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
